// File: rtl/mux_stream_sel_if.sv
// Handshake bundle between producer streams, the channel selector and its consumer.
// The master side drives the channel inputs and consumer ready; the slave side is the selector.
interface mux_stream_sel_if #(
    parameter int WIDTH = 16,
    parameter int NCH   = 8,
    parameter int SELW  = 3
);
    logic [WIDTH*NCH-1:0] D;
    logic [NCH-1:0]       V;
    logic [NCH-1:0]       ACK;
    logic                 MODE;
    logic [SELW-1:0]      S;
    logic [WIDTH-1:0]     O;
    logic                 OV;
    logic [SELW-1:0]      OSEL;
    logic                 ORDY;

    modport master (
        output D, V, MODE, S, ORDY,
        input  ACK, O, OV, OSEL
    );

    modport slave (
        input  D, V, MODE, S, ORDY,
        output ACK, O, OV, OSEL
    );
endinterface

// File: rtl/mux_stream_sel.sv
// N-channel registered stream selector: manual select or round-robin grant
// into a single output register with valid/ready back-pressure.
module mux_stream_sel #(
    parameter int WIDTH = 16,
    parameter int NCH   = 8,
    parameter int SELW  = 3
) (
    input  logic            CLK,
    input  logic            RST_N,
    mux_stream_sel_if.slave bus
);

    logic [WIDTH-1:0]     o_p1;
    logic                 vld_p1;
    logic [SELW-1:0]      osel_p1;
    logic [SELW-1:0]      ptr;
    logic [SELW-1:0]      ptr_nxt;
    logic                 ld;
    logic                 gnt_vld;
    logic [SELW-1:0]      gnt_idx;
    logic [SELW:0]        rr;
    logic [NCH-1:0]       v_sh;
    logic [WIDTH*NCH-1:0] d_sh;

    // First set valid at or after p, wrapping NCH-1 -> 0; returns {found, index}.
    function automatic logic [SELW:0] rr_pick(input logic [NCH-1:0] v, input logic [SELW-1:0] p);
        logic            found;
        logic [SELW-1:0] idx;
        logic [NCH-1:0]  sh;
        int              c;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            c = int'(p) + k;
            if (c >= NCH) c = c - NCH;
            sh = v >> c;
            if (!found && sh[0]) begin
                found = 1'b1;
                idx   = SELW'(c);
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        ld      = !vld_p1 || bus.ORDY;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        rr      = '0;
        v_sh    = '0;
        if (bus.MODE) begin
            rr      = rr_pick(bus.V, ptr);
            gnt_vld = rr[SELW];
            gnt_idx = rr[SELW-1:0];
        end else begin
            v_sh    = bus.V >> bus.S;
            gnt_vld = (int'(bus.S) < NCH) && v_sh[0];
            gnt_idx = bus.S;
        end
        // Grants exist only when the output register can take a word and reset is released.
        if (!RST_N || !ld) gnt_vld = 1'b0;
    end

    assign d_sh    = bus.D >> (int'(gnt_idx) * WIDTH);
    assign ptr_nxt = (gnt_idx == SELW'(NCH - 1)) ? '0 : gnt_idx + SELW'(1);
    assign bus.ACK = gnt_vld ? (NCH'(1) << gnt_idx) : '0;

    // Stage p1: output register; a consumed word and the next grant swap in one edge.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            o_p1    <= '0;
            vld_p1  <= 1'b0;
            osel_p1 <= '0;
            ptr     <= '0;
        end else if (ld) begin
            vld_p1 <= gnt_vld;
            if (gnt_vld) begin
                o_p1    <= d_sh[WIDTH-1:0];
                osel_p1 <= gnt_idx;
                if (bus.MODE) ptr <= ptr_nxt;
            end
        end
    end

    assign bus.O    = o_p1;
    assign bus.OV   = vld_p1;
    assign bus.OSEL = osel_p1;

endmodule

// File: tb/tb_mux_stream_sel.sv
// Scoreboard bench for mux_stream_sel: an 8-channel and a 5-channel instance share stimulus,
// a per-cycle reference model queues expected words, a negedge monitor compares.
module tb_mux_stream_sel;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_stream_sel_if #(.WIDTH(16), .NCH(8), .SELW(3)) b8 ();
    mux_stream_sel_if #(.WIDTH(16), .NCH(5), .SELW(3)) b5 ();

    mux_stream_sel #(.WIDTH(16), .NCH(8), .SELW(3)) dut8 (.CLK(clk), .RST_N(rst_n), .bus(b8));
    mux_stream_sel #(.WIDTH(16), .NCH(5), .SELW(3)) dut5 (.CLK(clk), .RST_N(rst_n), .bus(b5));

    typedef struct {
        logic [15:0] d;
        logic [2:0]  sel;
    } word_t;

    typedef struct {
        logic [7:0] ack;
        bit         granted;
        bit         rst;
    } rec_t;

    word_t wq8[$];
    word_t wq5[$];
    rec_t  rq8[$];
    rec_t  rq5[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] dall = '0;
    bit full8 = 1'b0, full5 = 1'b0;
    int ptr8 = 0, ptr5 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit bit_at(input logic [7:0] v, input int i);
        logic [7:0] t;
        t = v >> i;
        return t[0];
    endfunction

    // Reference behaviour for one cycle: who gets granted, and what the register looks like next.
    task automatic model(input int nch, input bit rn, input bit md, input int s,
                         input logic [7:0] vv, input bit rdy,
                         inout bit full, inout int ptr,
                         output rec_t r, output bit g, output int gi);
        bit ld;
        ld = !full || rdy;
        g  = 1'b0;
        gi = 0;
        if (rn && ld) begin
            if (!md) begin
                if (s < nch && bit_at(vv, s)) begin
                    g  = 1'b1;
                    gi = s;
                end
            end else begin
                for (int k = 0; k < nch; k++) begin
                    if (!g && bit_at(vv, (ptr + k) % nch)) begin
                        g  = 1'b1;
                        gi = (ptr + k) % nch;
                    end
                end
            end
        end
        r.ack     = g ? (8'd1 << gi) : 8'd0;
        r.granted = g;
        r.rst     = !rn;
        if (!rn) begin
            full = 1'b0;
            ptr  = 0;
        end else if (ld) begin
            full = g;
            if (g && md) ptr = (gi + 1) % nch;
        end
    endtask

    task automatic step(input bit rn, input bit md, input logic [2:0] s,
                        input logic [7:0] vv, input bit rdy);
        rec_t  r;
        bit    g;
        int    gi;
        word_t w;
        @(posedge clk);
        #1;
        rst_n   = rn;
        b8.MODE = md;  b8.S = s;  b8.V = vv;       b8.ORDY = rdy;  b8.D = dall;
        b5.MODE = md;  b5.S = s;  b5.V = vv[4:0];  b5.ORDY = rdy;  b5.D = dall[79:0];
        model(8, rn, md, int'(s), vv, rdy, full8, ptr8, r, g, gi);
        rq8.push_back(r);
        if (g) begin
            w.d   = 16'(dall >> (gi * 16));
            w.sel = 3'(gi);
            wq8.push_back(w);
        end
        model(5, rn, md, int'(s), vv & 8'h1F, rdy, full5, ptr5, r, g, gi);
        rq5.push_back(r);
        if (g) begin
            w.d   = 16'(dall >> (gi * 16));
            w.sel = 3'(gi);
            wq5.push_back(w);
        end
    endtask

    task automatic mon(input string tag, input rec_t r, input logic [7:0] ack, input logic ov,
                       input logic [15:0] o, input logic [2:0] osel, input logic rdy,
                       ref word_t wq[$], inout bit prev_rst);
        bit exp_ov;
        check({tag, "_ack"}, 32'(ack), 32'(r.ack));
        exp_ov = (wq.size() - int'(r.granted)) > 0;
        check({tag, "_ov"}, 32'(ov), 32'(exp_ov));
        if (prev_rst) begin
            check({tag, "_rst_o"}, 32'(o), 32'd0);
            check({tag, "_rst_osel"}, 32'(osel), 32'd0);
        end
        if (ov === 1'b1 && exp_ov) begin
            check({tag, "_o"}, 32'(o), 32'(wq[0].d));
            check({tag, "_osel"}, 32'(osel), 32'(wq[0].sel));
            if (rdy === 1'b1 && !r.rst) void'(wq.pop_front());
        end
        if (r.rst) wq.delete();
        prev_rst = r.rst;
    endtask

    initial begin
        rec_t r;
        bit   prev8 = 1'b1;
        bit   prev5 = 1'b1;
        forever begin
            @(negedge clk);
            if (rq8.size() > 0) begin
                r = rq8.pop_front();
                mon("n8", r, b8.ACK, b8.OV, b8.O, b8.OSEL, b8.ORDY, wq8, prev8);
            end
            if (rq5.size() > 0) begin
                r = rq5.pop_front();
                mon("n5", r, {3'b000, b5.ACK}, b5.OV, b5.O, b5.OSEL, b5.ORDY, wq5, prev5);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        b8.D = '0; b8.V = '0; b8.MODE = 1'b0; b8.S = '0; b8.ORDY = 1'b1;
        b5.D = '0; b5.V = '0; b5.MODE = 1'b0; b5.S = '0; b5.ORDY = 1'b1;

        // Reset held with all channels valid.
        for (int i = 0; i < 3; i++) begin
            dall = {$urandom, $urandom, $urandom, $urandom};
            step(1'b0, 1'b0, 3'd0, 8'hFF, 1'b1);
        end

        // Manual sweep with D[i] = i.
        dall = '0;
        for (int i = 0; i < 8; i++) dall = dall | (128'(i) << (i * 16));
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 3'(i), 8'hFF, 1'b1);

        // Round-robin fairness from P=0, then sparse pattern.
        step(1'b0, 1'b0, 3'd0, 8'hFF, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1);
        step(1'b0, 1'b0, 3'd0, 8'hFF, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'd0, 8'h84, 1'b1);

        // Back-pressure: hold a word for 5 cycles while V wiggles, then release.
        dall = {$urandom, $urandom, $urandom, $urandom};
        step(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 3'd0, 8'($urandom), 1'b0);
        step(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1);
        step(1'b1, 1'b1, 3'd0, 8'h00, 1'b1);

        // Boundaries: invalid selected channel, out-of-range select, RR wrap at NCH-1.
        step(1'b1, 1'b0, 3'd3, 8'hF7, 1'b1);
        step(1'b1, 1'b0, 3'd3, 8'hF7, 1'b1);
        step(1'b1, 1'b0, 3'd6, 8'hFF, 1'b1);
        step(1'b1, 1'b0, 3'd6, 8'hFF, 1'b1);
        step(1'b0, 1'b0, 3'd0, 8'hFF, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'd0, 8'h11, 1'b1);
        step(1'b1, 1'b1, 3'd0, 8'h10, 1'b1);
        step(1'b1, 1'b1, 3'd0, 8'h1F, 1'b1);

        // Mid-operation reset while full and stalled.
        step(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1);
        step(1'b1, 1'b1, 3'd0, 8'hFF, 1'b0);
        step(1'b0, 1'b1, 3'd0, 8'hFF, 1'b0);
        step(1'b1, 1'b1, 3'd0, 8'h28, 1'b1);
        step(1'b1, 1'b1, 3'd0, 8'h28, 1'b1);

        // Randomized traffic with mode switches, sparse valids, stalls and rare resets.
        for (int i = 0; i < 400; i++) begin
            dall = {$urandom, $urandom, $urandom, $urandom};
            step(($urandom_range(0, 49) != 0), 1'($urandom), 3'($urandom),
                 8'($urandom & $urandom), ($urandom_range(0, 3) != 0));
        end

        // Drain and confirm every expected word was observed.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 3'd0, 8'h00, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("drain_words8", 32'(wq8.size()), 32'd0);
        check("drain_words5", 32'(wq5.size()), 32'd0);
        check("drain_recs8", 32'(rq8.size()), 32'd0);
        check("drain_recs5", 32'(rq5.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
